bcd_to_seg7: RTL and testbench

//   Converts one 4-bit BCD digit {A,B,C,D} (A = MSB) to the seven segment

---
 rtl/seg7_pkg.sv | 28 ++
 rtl/bcd_seg7_lut.sv | 32 +++
 rtl/bcd_to_seg7.sv | 55 +++++
 tb/tb_bcd_to_seg7.sv | 118 +++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared segment patterns for the BCD to 7-segment decoder.
// Patterns are ordered abcdefg (bit 6 = a, bit 0 = g) and are active-high.
package seg7_pkg;

   localparam int SEG_W = 7;
   localparam int BCD_MAX = 9;

   localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
   localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
   localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
   localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
   localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   // Converts an active-high pattern to the pin polarity of the display.
   function automatic logic [SEG_W-1:0] applyPolarity(
      input logic [SEG_W-1:0] seg,
      input bit               activeLow
   );
      return activeLow ? ~seg : seg;
   endfunction

endpackage

// File: rtl/bcd_seg7_lut.sv
// Combinational lookup from a 4-bit code to an active-high segment pattern.
// Codes above 9 produce a blank pattern and raise o_invalid.
module bcd_seg7_lut
   import seg7_pkg::*;
(
   input  logic [3:0]       i_code,
   output logic [SEG_W-1:0] o_seg,
   output logic             o_invalid
);

   always_comb begin
      o_seg = SEG_BLANK;
      o_invalid = 1'b0;
      case (i_code)
         4'd0: o_seg = SEG_0;
         4'd1: o_seg = SEG_1;
         4'd2: o_seg = SEG_2;
         4'd3: o_seg = SEG_3;
         4'd4: o_seg = SEG_4;
         4'd5: o_seg = SEG_5;
         4'd6: o_seg = SEG_6;
         4'd7: o_seg = SEG_7;
         4'd8: o_seg = SEG_8;
         4'd9: o_seg = SEG_9;
         default: begin
            o_seg = SEG_BLANK;
            o_invalid = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/bcd_to_seg7.sv
// Registered BCD to 7-segment driver with selectable display polarity.
// Segments and err update one clock after the code is sampled.
module bcd_to_seg7
   import seg7_pkg::*;
#(
   parameter bit ACTIVE_LOW = 1'b0
)(
   input  logic clk,
   input  logic rst,
   input  logic A,
   input  logic B,
   input  logic C,
   input  logic D,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic f,
   output logic g,
   output logic err
);

   logic [3:0]       w_code;
   logic [SEG_W-1:0] w_segHigh;
   logic [SEG_W-1:0] w_segPins;
   logic             w_invalid;
   logic [SEG_W-1:0] r_seg;
   logic             r_err;

   assign w_code = {A, B, C, D};

   bcd_seg7_lut uLut (
      .i_code    (w_code),
      .o_seg     (w_segHigh),
      .o_invalid (w_invalid)
   );

   assign w_segPins = applyPolarity(w_segHigh, ACTIVE_LOW);

   // The reset value is the blank pattern in pin polarity, so the display is dark.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg <= applyPolarity(SEG_BLANK, ACTIVE_LOW);
         r_err <= 1'b0;
      end else begin
         r_seg <= w_segPins;
         r_err <= w_invalid;
      end
   end

   assign {a, b, c, d, e, f, g} = r_seg;
   assign err = r_err;

endmodule

// File: tb/tb_bcd_to_seg7.sv
// Directed bench for bcd_to_seg7, checking both display polarities side by side.
module tb_bcd_to_seg7;

   logic clk = 1'b0;
   logic clkEn = 1'b0;
   logic rst = 1'b0;
   logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;

   logic aH, bH, cH, dH, eH, fH, gH, errH;
   logic aL, bL, cL, dL, eL, fL, gL, errL;

   int checkCount = 0;
   int errorCount = 0;

   logic [6:0] expTab [0:9] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
   };

   bcd_to_seg7 #(.ACTIVE_LOW(1'b0)) dutHigh (
      .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
      .a(aH), .b(bH), .c(cH), .d(dH), .e(eH), .f(fH), .g(gH), .err(errH)
   );

   bcd_to_seg7 #(.ACTIVE_LOW(1'b1)) dutLow (
      .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .D(D),
      .a(aL), .b(bL), .c(cL), .d(dL), .e(eL), .f(fL), .g(gL), .err(errL)
   );

   // The clock only runs once enabled, so reset can be checked with no edges.
   always begin
      #5;
      if (clkEn) clk = ~clk;
   end

   task automatic applyStimulus(input logic [3:0] code);
      {A, B, C, D} = code;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got err,abcdefg=%b_%b expected %b_%b",
                  tag, got[7], got[6:0], exp[7], exp[6:0]);
      end
   endtask

   // expSeg is active-high; the common-anode instance must show its inverse.
   task automatic checkBoth(input string tag, input logic [6:0] expSeg, input logic expErr);
      checkOutput({tag, "_hi"}, {errH, aH, bH, cH, dH, eH, fH, gH}, {expErr, expSeg});
      checkOutput({tag, "_lo"}, {errL, aL, bL, cL, dL, eL, fL, gL}, {expErr, ~expSeg});
   endtask

   task automatic waitEdge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2 rst = 1'b1;
      #1 checkBoth("rstNoClk", 7'b0000000, 1'b0);
      #2 rst = 1'b0;
      #2 clkEn = 1'b1;

      for (int i = 0; i <= 9; i++) begin
         applyStimulus(4'(i));
         if (i > 0) begin
            #1 checkBoth($sformatf("lag%0d", i), expTab[i-1], 1'b0);
         end
         waitEdge();
         checkBoth($sformatf("digit%0d", i), expTab[i], 1'b0);
      end

      for (int i = 10; i <= 15; i++) begin
         applyStimulus(4'(i));
         waitEdge();
         checkBoth($sformatf("invalid%0d", i), 7'b0000000, 1'b1);
      end

      applyStimulus(4'd8);
      waitEdge();
      checkBoth("recover8", 7'b1111111, 1'b0);

      applyStimulus(4'd3);
      #1 applyStimulus(4'd5);
      #1 applyStimulus(4'd3);
      #1 checkBoth("midHold", 7'b1111111, 1'b0);
      waitEdge();
      checkBoth("midEdge3", 7'b1111001, 1'b0);

      applyStimulus(4'd8);
      waitEdge();
      checkBoth("pre8", 7'b1111111, 1'b0);
      #1 rst = 1'b1;
      #1 checkBoth("rstMid", 7'b0000000, 1'b0);
      applyStimulus(4'd4);
      @(negedge clk);
      rst = 1'b0;
      waitEdge();
      checkBoth("post4", 7'b0110011, 1'b0);

      applyStimulus(4'd12);
      waitEdge();
      checkBoth("errSet", 7'b0000000, 1'b1);
      #1 rst = 1'b1;
      #1 checkBoth("errRst", 7'b0000000, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'd0);
      waitEdge();
      checkBoth("after0", 7'b1111110, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
